// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bundle for if_id_stage: redirect and interrupt controls in, fetch PC and ID latch out.
interface if_id_stage_if;
   localparam int unsigned XLEN = 32;

   logic            stall;
   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            eret;
   logic [XLEN-1:0] epc_in;
   logic            intr;
   logic            ie;
   logic [XLEN-1:0] inst_in;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_inst;
   logic            id_valid;
   logic [XLEN-1:0] epc_out;
   logic            epc_we;
   logic            inta;

   modport master (
      output stall, br_taken, br_target, eret, epc_in, intr, ie, inst_in,
      input  if_pc, id_pc, id_inst, id_valid, epc_out, epc_we, inta
   );

   modport slave (
      input  stall, br_taken, br_target, eret, epc_in, intr, ie, inst_in,
      output if_pc, id_pc, id_inst, id_valid, epc_out, epc_we, inta
   );
endinterface

// File: rtl/if_id_stage.sv
// Fetch PC, next-PC selection and IF/ID pipeline register with interrupt entry.
// Optional feature macro: IF_STAGE_INTR_EN (interrupt FSM and take logic).
module if_id_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] INTR_VECTOR = 32'h0000_0008
) (
   input logic           clk,
   input logic           rst,
   if_id_stage_if.slave  bus
);
   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_id_pc;
   logic [XLEN-1:0] r_id_inst;
   logic            r_id_valid;
   logic            w_take;
   logic            w_flush;

`ifdef IF_STAGE_INTR_EN
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_ENTER = 2'd1,
      ST_ISR   = 2'd2
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_epc;
   logic            r_epc_we;
   logic            r_inta;

   // Redirects and stalls defer the take; intr is a level so it is retried next RUN cycle.
   assign w_take = (r_state == ST_RUN) && bus.intr && bus.ie &&
                   !bus.stall && !bus.br_taken && !bus.eret;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_RUN;
         r_epc    <= XLEN'(0);
         r_epc_we <= 1'b0;
         r_inta   <= 1'b0;
      end else begin
         r_epc_we <= w_take;
         r_inta   <= w_take;
         if (w_take) r_epc <= r_pc;
         case (r_state)
            ST_RUN:   if (w_take) r_state <= ST_ENTER;
            ST_ENTER: r_state <= ST_ISR;
            ST_ISR:   if (bus.eret && !bus.br_taken) r_state <= ST_RUN;
            default:  r_state <= ST_RUN;
         endcase
      end
   end

   assign bus.epc_out = r_epc;
   assign bus.epc_we  = r_epc_we;
   assign bus.inta    = r_inta;
`else
   logic w_unused_intr;

   assign w_take        = 1'b0;
   assign w_unused_intr = bus.intr ^ bus.ie;
   assign bus.epc_out   = XLEN'(0);
   assign bus.epc_we    = 1'b0;
   assign bus.inta      = 1'b0;
`endif

   assign w_flush = bus.br_taken || bus.eret || w_take;

   // PC select and IF/ID latch; branch beats eret beats interrupt beats stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_id_pc    <= XLEN'(0);
         r_id_inst  <= XLEN'(0);
         r_id_valid <= 1'b0;
      end else begin
         if (bus.br_taken)   r_pc <= bus.br_target;
         else if (bus.eret)  r_pc <= bus.epc_in;
         else if (w_take)    r_pc <= INTR_VECTOR;
         else if (!bus.stall) r_pc <= r_pc + XLEN'(4);

         if (w_flush) begin
            r_id_pc    <= r_pc;
            r_id_inst  <= XLEN'(0);
            r_id_valid <= 1'b0;
         end else if (!bus.stall) begin
            r_id_pc    <= r_pc;
            r_id_inst  <= bus.inst_in;
            r_id_valid <= 1'b1;
         end
      end
   end

   assign bus.if_pc    = r_pc;
   assign bus.id_pc    = r_id_pc;
   assign bus.id_inst  = r_id_inst;
   assign bus.id_valid = r_id_valid;
endmodule
